// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame constants and FSM state encoding for spi_master_arb
//   SPI_BYTE_W        bits per frame payload
//   SPI_FRAME_PULSES  sclk pulses per frame (lead + data + trail)
//   SPI_LEAD_PULSES   dummy pulses sent before the first data bit
package spi_pkg;
    localparam int SPI_BYTE_W       = 8;
    localparam int SPI_FRAME_PULSES = 10;
    localparam int SPI_LEAD_PULSES  = 1;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;
endpackage

// File: rtl/spi_master_arb_if.sv
// spi_master_arb_if: requester fabric and SPI pin bundle for spi_master_arb
//   req/tx_data     requester -> master (level request, byte i at [8*i+7:8*i])
//   gnt/ack/busy    master -> requesters
//   sclk/mosi/cs    master -> SPI receiver pins
interface spi_master_arb_if
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]            req, gnt, ack;
    logic [SPI_BYTE_W*NUM_REQ-1:0] tx_data;
    logic                          busy, sclk, mosi, cs;
    modport master (input req, tx_data, output gnt, ack, busy, sclk, mosi, cs);
    modport slave  (output req, tx_data, input gnt, ack, busy, sclk, mosi, cs);
endinterface

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick starting at the pointer
//   req_i  request vector
//   ptr_i  index with highest priority this round
//   en_i   pick enable
//   gnt_o  one-hot grant, zero when disabled or no request
module spi_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    input  logic                       en_i,
    output logic [NUM_REQ-1:0]         gnt_o
);
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0] idx;
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        // scan farthest-first so the requester nearest the pointer is written last and wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_i) + k) % NUM_REQ);
            if (en_i && req_i[idx])
                gnt_o = NUM_REQ'(1) << idx;
        end
    end
endmodule

// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin arbiter sharing one SPI write link among NUM_REQ requesters
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    spi_master_arb_if master side: req/tx_data in; gnt/ack/busy/sclk/mosi/cs out
module spi_master_arb
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 2
) (
    input logic              clk,
    input logic              rst_n,
    spi_master_arb_if.master bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    state_t                state_q;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [DW-1:0]         div_q;
    logic [3:0]            pulse_q;
    logic [SPI_BYTE_W-1:0] sh_q, byte_d;
    logic [NUM_REQ-1:0]    gnt_q, ack_q, gnt_d;
    logic                  busy_q, sclk_q, mosi_q, cs_q;
    logic                  div_end;

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt_d)
    );

    assign div_end = div_q == DIV_LAST;

    always_comb begin
        ptr_d  = ptr_q;
        byte_d = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_d[i]) begin
                ptr_d  = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
                byte_d = bus.tx_data[SPI_BYTE_W*i +: SPI_BYTE_W];
            end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            div_q   <= '0;
            pulse_q <= '0;
            sh_q    <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            ack_q <= '0;
            div_q <= (state_q == IDLE || div_end) ? '0 : div_q + 1'b1;
            case (state_q)
                IDLE: if (|gnt_d) begin
                    state_q <= SETUP;
                    gnt_q   <= gnt_d;
                    sh_q    <= byte_d;
                    ptr_q   <= ptr_d;
                    cs_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                SETUP: if (div_end) begin
                    state_q <= SHIFT;
                    sclk_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    pulse_q <= 4'd1;
                end
                SHIFT: if (div_end) begin
                    if (sclk_q)
                        sclk_q <= 1'b0;
                    else if (pulse_q == 4'(SPI_FRAME_PULSES)) begin
                        state_q <= HOLD;
                        mosi_q  <= 1'b0;
                    end else begin
                        pulse_q <= pulse_q + 4'd1;
                        sclk_q  <= 1'b1;
                        // the pulse about to start carries data only if it follows the lead pulse(s)
                        if (pulse_q >= 4'(SPI_LEAD_PULSES) && pulse_q < 4'(SPI_LEAD_PULSES + SPI_BYTE_W)) begin
                            mosi_q <= sh_q[SPI_BYTE_W-1];
                            sh_q   <= sh_q << 1;
                        end else
                            mosi_q <= 1'b0;
                    end
                end
                HOLD: if (div_end) begin
                    state_q <= GAP;
                    cs_q    <= 1'b1;
                    gnt_q   <= '0;
                    ack_q   <= gnt_q;
                end
                GAP: if (div_end) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;
    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.cs   = cs_q;
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb: self-checking bench for spi_master_arb with a behavioural negedge SPI receiver
module tb_spi_master_arb;
    typedef struct {
        int         len;
        int         gap;
        logic [3:0] gnt;
        logic [7:0] data;
        logic       shape_ok;
        logic       ack_ok;
        logic       gnt_ok;
    } frame_t;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          n;
        logic [7:0]  ord;
    } vec_t;

    logic   clk = 1'b0;
    logic   rstn0, rstn1;
    int     total = 0, passed = 0;
    int     rd0 = 0, rd1 = 0;
    frame_t fq0[$], fq1[$];

    always #5 clk = ~clk;

    spi_master_arb_if #(.NUM_REQ(4)) b0 ();
    spi_master_arb_if #(.NUM_REQ(4)) b1 ();

    spi_master_arb #(.NUM_REQ(4), .CLK_DIV(2)) dut0 (.clk(clk), .rst_n(rstn0), .bus(b0));
    spi_master_arb #(.NUM_REQ(4), .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rstn1), .bus(b1));

    // receiver model: samples mosi on every sclk fall while cs is low and records each frame
    for (genvar g = 0; g < 2; g++) begin : mon
        logic       rn, cs, sclk, mosi;
        logic [3:0] gnt, ack;
        assign rn   = g == 0 ? rstn0  : rstn1;
        assign cs   = g == 0 ? b0.cs   : b1.cs;
        assign sclk = g == 0 ? b0.sclk : b1.sclk;
        assign mosi = g == 0 ? b0.mosi : b1.mosi;
        assign gnt  = g == 0 ? b0.gnt  : b1.gnt;
        assign ack  = g == 0 ? b0.ack  : b1.ack;
        int         stray = 0, low_n = 0, high_n = 0, falls = 0, gap_n = 0;
        logic [9:0] bits = '0;
        logic [3:0] fg = '0;
        logic       in_frame = 1'b0, sclk_p = 1'b0, gnt_bad = 1'b0;
        always @(negedge clk) begin
            frame_t f;
            if (!rn) begin
                in_frame = 1'b0;
                sclk_p   = 1'b0;
                high_n   = 0;
            end else begin
                if (!cs) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        low_n    = 0;
                        falls    = 0;
                        bits     = '0;
                        fg       = gnt;
                        gnt_bad  = 1'b0;
                        gap_n    = high_n;
                    end
                    low_n++;
                    if (gnt != fg) gnt_bad = 1'b1;
                    if (sclk_p && !sclk) begin
                        if (falls < 10) bits[9-falls] = mosi;
                        falls++;
                    end
                    if (ack != 0) stray++;
                    high_n = 0;
                end else begin
                    if (in_frame) begin
                        f.len      = low_n;
                        f.gap      = gap_n;
                        f.gnt      = fg;
                        f.data     = bits[8:1];
                        f.shape_ok = falls == 10 && !bits[9] && !bits[0];
                        f.ack_ok   = ack == fg;
                        f.gnt_ok   = !gnt_bad && gnt == 0;
                        if (g == 0) fq0.push_back(f); else fq1.push_back(f);
                        in_frame = 1'b0;
                        high_n   = 1;
                    end else begin
                        high_n++;
                        if (ack != 0) stray++;
                    end
                    if (sclk != sclk_p) stray++;
                end
                sclk_p = sclk;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic get_frame(input int d, output frame_t f, output bit ok);
        int t = 0;
        while ((d == 0 ? fq0.size() <= rd0 : fq1.size() <= rd1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = d == 0 ? fq0.size() > rd0 : fq1.size() > rd1;
        if (ok) begin
            if (d == 0) begin f = fq0[rd0]; rd0++; end
            else begin f = fq1[rd1]; rd1++; end
        end
    endtask

    task automatic check_frame(input int d, input int idx, input logic [7:0] byt, input int len, input int gap);
        frame_t f;
        bit     ok;
        get_frame(d, f, ok);
        chk("frame_arrived", 32'(ok), 1);
        if (ok) begin
            chk("frame_gnt", 32'(f.gnt), 32'(4'b0001 << idx));
            chk("frame_data", 32'(f.data), 32'(byt));
            chk("cs_low_cycles", f.len, len);
            chk("frame_shape", 32'(f.shape_ok), 1);
            chk("ack_and_gnt", 32'({f.ack_ok, f.gnt_ok}), 3);
            if (gap >= 0) chk("cs_high_gap", f.gap, gap);
        end
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while ((d == 0 ? b0.req : b1.req) != 0 && t < 5000) begin
            @(negedge clk);
            if (d == 0) b0.req = b0.req & ~b0.ack;
            else b1.req = b1.req & ~b1.ack;
            t++;
        end
        chk("round_done", 32'(d == 0 ? b0.req : b1.req), 0);
    endtask

    task automatic do_reset0();
        rstn0 = 1'b0;
        repeat (3) @(negedge clk);
        rstn0 = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[6];
        int          acks, t, rises, idx, n, best, ptr_m;
        int          exp_idx[4];
        logic        sp;
        logic [3:0]  mask, rem;
        logic [31:0] data;

        tbl[0] = '{4'b0100, 32'hA1B2C3D4, 1, 8'h02};
        tbl[1] = '{4'b1001, 32'h5E6F7081, 2, 8'h03};
        tbl[2] = '{4'b0110, 32'h0F1E2D3C, 2, 8'h09};
        tbl[3] = '{4'b0011, 32'h96877869, 2, 8'h04};
        tbl[4] = '{4'b1010, 32'hCAFEF00D, 2, 8'h07};
        tbl[5] = '{4'b1111, 32'h80402001, 4, 8'h4E};

        b0.req = '0; b0.tx_data = '0;
        b1.req = '0; b1.tx_data = '0;
        rstn0 = 1'b0; rstn1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_sclk_mosi_busy", 32'({b0.cs, b0.sclk, b0.mosi, b0.busy}), 32'b1000);
        chk("rst_gnt_ack", 32'({b0.gnt, b0.ack}), 0);
        chk("rst_dut1_idle", 32'({b1.cs, b1.sclk, b1.mosi, b1.busy}), 32'b1000);
        rstn0 = 1'b1; rstn1 = 1'b1;
        @(negedge clk);

        b0.tx_data = 32'h000000A5; b0.req = 4'b0001;
        @(negedge clk);
        chk("single_gnt", 32'(b0.gnt), 32'b0001);
        chk("single_busy_cs", 32'({b0.busy, b0.cs}), 32'b10);
        wait_done(0);
        check_frame(0, 0, 8'hA5, 44, -1);

        do_reset0();
        b0.tx_data = 32'h44332211; b0.req = 4'b1111;
        acks = 0; t = 0;
        while (acks < 5 && t < 2000) begin
            @(negedge clk);
            if (b0.ack != 0) acks++;
            t++;
        end
        b0.req = '0;
        chk("rr_held_acks", acks, 5);
        for (int k = 0; k < 5; k++)
            check_frame(0, k % 4, 8'(8'h11 * (k % 4 + 1)), 44, k == 0 ? -1 : 3);

        for (int e = 0; e < 6; e++) begin
            b0.tx_data = tbl[e].data; b0.req = tbl[e].mask;
            wait_done(0);
            for (int k = 0; k < tbl[e].n; k++) begin
                idx = int'(tbl[e].ord[2*k +: 2]);
                check_frame(0, idx, tbl[e].data[8*idx +: 8], 44, k == 0 ? -1 : 3);
            end
        end

        b0.tx_data = 32'h0000005A; b0.req = 4'b0001;
        t = 0;
        while (b0.gnt == 0 && t < 100) begin @(negedge clk); t++; end
        b0.tx_data = '1; b0.req = '0;
        acks = 0;
        repeat (80) begin @(negedge clk); if (b0.ack != 0) acks++; end
        chk("hold_acks", acks, 1);
        check_frame(0, 0, 8'h5A, 44, -1);

        ptr_m = 1;
        for (int r = 0; r < 12; r++) begin
            mask = 4'($urandom_range(1, 15));
            data = $urandom;
            b0.tx_data = data; b0.req = mask;
            n = 0; rem = mask;
            while (rem != 0) begin
                best = -1;
                for (int i = 0; i < 4; i++)
                    if (rem[i] && (best < 0 || (i - ptr_m + 4) % 4 < (best - ptr_m + 4) % 4)) best = i;
                exp_idx[n] = best;
                n++;
                rem[best] = 1'b0;
                ptr_m = (best + 1) % 4;
            end
            wait_done(0);
            for (int k = 0; k < n; k++)
                check_frame(0, exp_idx[k], data[8*exp_idx[k] +: 8], 44, k == 0 ? -1 : 3);
        end

        b0.tx_data = 32'h00C30000; b0.req = 4'b0100;
        rises = 0; t = 0; sp = 1'b0;
        while (rises < 5 && t < 200) begin
            @(negedge clk);
            if (b0.sclk && !sp) rises++;
            sp = b0.sclk;
            t++;
        end
        chk("pulse5_reached", rises, 5);
        rstn0 = 1'b0; b0.req = '0;
        @(negedge clk);
        chk("midrst_cs_sclk_mosi_busy", 32'({b0.cs, b0.sclk, b0.mosi, b0.busy}), 32'b1000);
        chk("midrst_gnt_ack", 32'({b0.gnt, b0.ack}), 0);
        @(negedge clk);
        rstn0 = 1'b1;
        b0.tx_data = 32'h77006600; b0.req = 4'b1010;
        @(negedge clk);
        chk("post_rst_first_gnt", 32'(b0.gnt), 32'b0010);
        wait_done(0);
        check_frame(0, 1, 8'h66, 44, -1);
        check_frame(0, 3, 8'h77, 44, 3);

        b1.tx_data = 32'h0000FF00; b1.req = 4'b0011;
        wait_done(1);
        check_frame(1, 0, 8'h00, 22, -1);
        check_frame(1, 1, 8'hFF, 22, 2);

        chk("stray_events_div2", mon[0].stray, 0);
        chk("stray_events_div1", mon[1].stray, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
